uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter behind the `tx` pin among N on-FPGA byte-stream requesters, such as the host-response path and local debug/status emitters. Grants are packet-granular: once a requester wins, it owns the transmitter until it delivers a byte flagged `last`, or until it stalls past a timeout. The block sits between the requesters and the UART TX serializer, inside the top level next to the manta core.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; legal range 2–4.
- `TIMEOUT`, default 1024: mid-packet stall limit, in clock cycles; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_data`  in  8*N_REQ  byte from requester i, at bits [8i+7:8i].
- `req_valid`  in  N_REQ  requester i presents a byte.
- `req_last`  in  N_REQ  the byte presented by i ends its packet.
- `req_ready`  out  N_REQ  byte from i is accepted this cycle.
- `grant`  out  N_REQ  one-hot owner of the transmitter; all-zero when idle.
- `tx_data`  out  8  byte to the serializer.
- `tx_start`  out  1  one-cycle pulse that launches `tx_data`.
- `tx_done`  in  1  one-cycle pulse from the serializer when the byte has fully shifted out.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked for stalling.

## Operation
- **FSM states:** IDLE, ISSUE, BUSY.
- **IDLE:**
  - `grant` = 0 and `req_ready` = 0.
  - If any `req_valid` is high, select the first set bit searching upward from `ptr+1`, wrapping modulo N_REQ.
  - Register the selection as `grant`, clear the stall counter, and go to ISSUE.
- **ISSUE:**
  - `req_ready[g]` = `grant[g]` & `req_valid[g]`. This is combinational from state, grant and valid, with no dependence on `tx_done`.
  - On handshake: `tx_data` <= byte, `tx_start` <= 1 for exactly the next cycle, latch `req_last[g]`, go to BUSY.
  - With no handshake, the stall counter increments. When it reaches TIMEOUT-1 with valid still low:
    - pulse `timeout_err` the next cycle;
    - `ptr` <= g;
    - clear `grant`;
    - go to IDLE, discarding the partial packet.
- **BUSY:**
  - `req_ready` = 0 and `tx_data` is held stable.
  - On `tx_done`, if the latched last flag is set: `ptr` <= g, clear `grant`, go to IDLE.
  - Otherwise: clear the stall counter and return to ISSUE.
- **Fairness:** non-granted requesters never see `req_ready`. The pointer advances only when a packet ends or times out, so a requester cannot win twice in a row while another is waiting.
- **Ignored inputs:**
  - `tx_done` outside BUSY is ignored.
  - `req_last` on a non-handshake cycle is ignored.
  - Inputs from non-granted requesters are ignored.
- **Stall counter:** width is $clog2(TIMEOUT); it saturates and never wraps.

## Timing
- **Reset values:**
  - state = IDLE;
  - `grant`, `req_ready`, `tx_start`, `timeout_err` = 0;
  - `tx_data` = 8'h00;
  - `ptr` = N_REQ-1, so requester 0 has first priority;
  - stall counter = 0.
- **Arbitration latency:** `req_valid` rises in cycle t (IDLE) → `grant` in t+1 → `req_ready` in t+1 → `tx_start` in t+2.
- **Back-to-back bytes:** `tx_done` in cycle u → ISSUE in u+1 → `req_ready` in u+1 if valid → `tx_start` in u+2. This gives 2 overhead cycles per byte.
- **Packet end:** after `tx_done` for the last byte, IDLE is in u+1. The next grant appears at u+2, and its arbitration excludes the pointer of the just-finished owner.
- **Reset mid-operation:** `rst` in any state forces reset values on the next edge. A `tx_start` pulse already registered is cleared, and no `tx_start` is issued in the cycle after `rst`. The serializer finishing an in-flight byte is tolerated, because its `tx_done` arrives in IDLE and is ignored.
- **Simultaneous events:**
  - `tx_done` and new requests in the same cycle: the BUSY transition takes effect first; arbitration happens in IDLE on the following cycle.
  - Timeout and `req_valid` rising in the same cycle: the timeout wins.
- `timeout_err` and `tx_start` are never asserted in the same cycle.

## Test plan
- **Single requester:** after reset, req0 sends a 3-byte packet 8'h41, 8'h42, 8'h43 with `last` on 8'h43, serializer `tx_done` 10 cycles after each `tx_start` → three `tx_start` pulses carrying 41/42/43 in order, `grant` = 2'b01 throughout, back to 0 one cycle after the final `tx_done`.
- **Contention:** req0 and req1 both valid in the same cycle, 2-byte packets each → req0 is served first (`ptr` reset), then req1. Bytes never interleave. Arbitration latency is 2 cycles per grant.
- **Round-robin:** req0 held continuously valid with 1-byte packets, req1 requests during req0's packet → the next grant goes to req1, not req0. Grant order is 0,1,0,1.
- **Timeout:** TIMEOUT=8; req1 granted, sends one non-last byte, then drops valid → `timeout_err` pulses once, exactly 8 cycles after re-entering ISSUE. `grant` clears in the same cycle, and a pending req0 is granted on the next cycle.
- **Reset mid-packet:** `rst` asserted while BUSY on byte 2 of 4 → all outputs reach reset values on the next edge. A stray `tx_done` in the following cycle produces no `tx_start`. A fresh packet then completes normally.
- **Back-pressure:** the serializer delays `tx_done` by 100 cycles → `req_ready` stays 0 and `tx_data` stays stable for the entire BUSY period. No timeout fires, since the stall counter runs only in ISSUE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter among N_REQ byte streams.
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_done,
  output logic               timeout_err
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d, gidx_q, gidx_d, sel;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           last_q, last_d, tx_start_q, tx_start_d, timeout_err_q, timeout_err_d;
  logic           hs, expire;
  logic [N_REQ-1:0] gmask;
  assign gmask       = N_REQ'(1) << gidx_q;
  assign expire      = cnt_q == CW'(TIMEOUT - 1);
  // a stall that expires this cycle wins over a late-arriving byte
  assign hs          = (state_q == ISSUE) && req_valid[gidx_q] && !expire;
  assign req_ready   = hs ? gmask : '0;
  assign grant       = (state_q == IDLE) ? '0 : gmask;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign timeout_err = timeout_err_q;
  // descending scan so the nearest set bit above ptr is the last one written
  always_comb begin
    sel = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req_valid[(int'(ptr_q) + k) % N_REQ]) sel = PW'((int'(ptr_q) + k) % N_REQ);
  end
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: if (|req_valid) begin
        gidx_d  = sel;
        cnt_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: if (hs) begin
        tx_data_d  = req_data[8*gidx_q +: 8];
        tx_start_d = 1'b1;
        last_d     = req_last[gidx_q];
        state_d    = BUSY;
      end else if (expire) begin
        timeout_err_d = 1'b1;
        ptr_d         = gidx_q;
        state_d       = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      BUSY: if (tx_done) begin
        ptr_d   = last_q ? gidx_q : ptr_q;
        cnt_d   = '0;
        state_d = last_q ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(N_REQ - 1);
      gidx_q        <= '0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, packet ownership, timeout, reset and back-pressure.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req_data = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        timeout_err;
  int          n_chk = 0;
  int          n_err = 0;

  uart_tx_arbiter #(.N_REQ(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .tx_data(tx_data), .tx_start(tx_start),
    .tx_done(tx_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    tx_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_grant", grant, 0);
    check("rst_ready", req_ready, 0);
    check("rst_start", tx_start, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_data", tx_data, 0);
  endtask

  // Called in the ISSUE cycle where requester r should handshake; returns in the cycle after tx_done.
  task automatic xfer(input int r, input logic [7:0] exp, input logic nv, input logic [7:0] nd,
                      input logic nl, input int dly);
    logic bad;
    bad = 1'b0;
    check("ready", req_ready, 1 << r);
    check("grant", grant, 1 << r);
    step();
    check("start", tx_start, 1);
    check("txdata", tx_data, exp);
    req_valid[r] = nv;
    req_data[8*r +: 8] = nd;
    req_last[r] = nl;
    repeat (dly) begin
      step();
      bad |= (tx_data !== exp) || (req_ready !== 2'b00) || (tx_start !== 1'b0) ||
             (timeout_err !== 1'b0) || (grant !== 2'(1 << r));
    end
    check("busy_stable", bad, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    // single requester, 3-byte packet
    do_reset();
    req_valid = 2'b01; req_data[7:0] = 8'h41; req_last = 2'b00;
    check("idle_no_ready", req_ready, 0);
    step();
    xfer(0, 8'h41, 1, 8'h42, 0, 10);
    xfer(0, 8'h42, 1, 8'h43, 1, 10);
    xfer(0, 8'h43, 0, 8'h00, 0, 10);
    check("single_end_grant", grant, 0);
    step();
    check("single_idle_grant", grant, 0);
    // contention: req0 first after reset, then req1
    do_reset();
    req_valid = 2'b11; req_data = 16'hB0A0; req_last = 2'b00;
    step();
    check("cont_first", grant, 2'b01);
    xfer(0, 8'hA0, 1, 8'hA1, 1, 4);
    xfer(0, 8'hA1, 0, 8'h00, 0, 4);
    check("cont_gap", grant, 0);
    step();
    check("cont_second", grant, 2'b10);
    xfer(1, 8'hB0, 1, 8'hB1, 1, 4);
    xfer(1, 8'hB1, 0, 8'h00, 0, 4);
    check("cont_done", grant, 0);
    // round-robin: grant order 0,1,0,1
    do_reset();
    req_valid = 2'b01; req_data[7:0] = 8'hC0; req_last = 2'b01;
    step();
    req_valid[1] = 1'b1; req_data[15:8] = 8'hD0; req_last[1] = 1'b1;
    xfer(0, 8'hC0, 1, 8'hC1, 1, 3);
    step();
    check("rr_1", grant, 2'b10);
    xfer(1, 8'hD0, 1, 8'hD1, 1, 3);
    step();
    check("rr_2", grant, 2'b01);
    xfer(0, 8'hC1, 0, 8'h00, 0, 3);
    step();
    check("rr_3", grant, 2'b10);
    xfer(1, 8'hD1, 0, 8'h00, 0, 3);
    step();
    check("rr_idle", grant, 0);
    // timeout: req1 stalls mid-packet, req0 pending
    do_reset();
    req_valid = 2'b10; req_data[15:8] = 8'hE0; req_last = 2'b00;
    step();
    xfer(1, 8'hE0, 0, 8'h00, 0, 3);
    req_valid[0] = 1'b1; req_data[7:0] = 8'hF0; req_last[0] = 1'b1;
    check("to_issue_ready", req_ready, 0);
    repeat (7) step();
    check("to_before", timeout_err, 0);
    check("to_before_grant", grant, 2'b10);
    step();
    check("to_pulse", timeout_err, 1);
    check("to_grant_clr", grant, 0);
    check("to_no_start", tx_start, 0);
    step();
    check("to_once", timeout_err, 0);
    check("to_next_grant", grant, 2'b01);
    xfer(0, 8'hF0, 0, 8'h00, 0, 3);
    check("to_done", grant, 0);
    // reset while BUSY on byte 2 of 4
    do_reset();
    req_valid = 2'b01; req_data[7:0] = 8'h10; req_last = 2'b00;
    step();
    xfer(0, 8'h10, 1, 8'h11, 0, 5);
    step();
    check("mid_start", tx_start, 1);
    check("mid_data", tx_data, 8'h11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 2'b00;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_data", tx_data, 0);
    check("mid_rst_start", tx_start, 0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("mid_stray_start", tx_start, 0);
    check("mid_stray_grant", grant, 0);
    req_valid = 2'b01; req_data[7:0] = 8'h20; req_last = 2'b01;
    step();
    xfer(0, 8'h20, 0, 8'h00, 0, 3);
    check("mid_fresh_done", grant, 0);
    // back-pressure: 100-cycle serializer delay, requester changes data meanwhile
    do_reset();
    req_valid = 2'b01; req_data[7:0] = 8'h55; req_last = 2'b01;
    step();
    xfer(0, 8'h55, 1, 8'h66, 1, 100);
    check("bp_idle", grant, 0);
    check("bp_no_terr", timeout_err, 0);
    step();
    xfer(0, 8'h66, 0, 8'h00, 0, 3);
    check("bp_done", grant, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
